left_shift_arbiter: RTL



---
 rtl/left_shift_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/left_shift_arbiter.sv
// Round-robin arbiter sharing one 10-bit left shifter between two clients.
// Latency: response one cycle after request handshake; one result per cycle.
// Backpressure: held result blocks both request readies until its owner drains.

module left_shifter_10 (
    input  logic [9:0] in_dat,
    input  logic [3:0] amt_dat,
    output logic [9:0] out_dat
);

    // Amounts of 10 and above push every bit out of the 10-bit result.
    assign out_dat = in_dat << amt_dat;

endmodule

module left_shift_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [9:0] req0_in,
    input  logic [3:0] req0_amt,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [9:0] req1_in,
    input  logic [3:0] req1_amt,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [9:0] rsp0_out,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [9:0] rsp1_out
);

    logic       res_vld_q,    res_vld_d;
    logic       res_owner_q,  res_owner_d;
    logic [9:0] res_dat_q,    res_dat_d;
    logic       last_grant_q, last_grant_d;

    logic       drain;
    logic       can_accept;
    logic       gnt0;
    logic       gnt1;
    logic       hs_any;
    logic [9:0] shift_in_dat;
    logic [3:0] shift_amt_dat;
    logic [9:0] shift_out_dat;

    left_shifter_10 u_shifter (
        .in_dat  (shift_in_dat),
        .amt_dat (shift_amt_dat),
        .out_dat (shift_out_dat)
    );

    always_comb begin
        drain      = res_vld_q & (res_owner_q ? rsp1_ready : rsp0_ready);
        can_accept = ~res_vld_q | drain;

        // Under contention the client not granted last time wins.
        gnt0 = req0_valid & (~req1_valid | last_grant_q);
        gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

        req0_ready = can_accept & gnt0;
        req1_ready = can_accept & gnt1;
        hs_any     = req0_ready | req1_ready;

        shift_in_dat  = gnt1 ? req1_in  : req0_in;
        shift_amt_dat = gnt1 ? req1_amt : req0_amt;

        res_vld_d    = res_vld_q;
        res_owner_d  = res_owner_q;
        res_dat_d    = res_dat_q;
        last_grant_d = last_grant_q;

        if (drain) begin
            res_vld_d = 1'b0;
        end
        // A refill in the same cycle as a drain overrides the clear above.
        if (hs_any) begin
            res_vld_d    = 1'b1;
            res_owner_d  = req1_ready;
            res_dat_d    = shift_out_dat;
            last_grant_d = req1_ready;
        end

        rsp0_valid = res_vld_q & ~res_owner_q;
        rsp1_valid = res_vld_q &  res_owner_q;
        rsp0_out   = res_owner_q ? 10'h000 : res_dat_q;
        rsp1_out   = res_owner_q ? res_dat_q : 10'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_vld_q    <= 1'b0;
            res_owner_q  <= 1'b0;
            res_dat_q    <= 10'h000;
            last_grant_q <= 1'b1;
        end else begin
            res_vld_q    <= res_vld_d;
            res_owner_q  <= res_owner_d;
            res_dat_q    <= res_dat_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
